// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: folds E0/F0 prefixes into key events,
// queues them in a show-ahead FIFO and counts protocol/parity errors.
module ps2_scancode_decoder #(
    parameter int DEPTH     = 8,
    parameter int ERR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       data_req,
    input  logic [7:0]                 data,
    input  logic                       data_err,
    input  logic                       data_ack,
    output logic                       ev_valid,
    output logic [7:0]                 ev_code,
    output logic                       ev_ext,
    output logic                       ev_rel,
    input  logic                       ev_rd,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [ERR_WIDTH-1:0]       err_count,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    state_t        nxt;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          accept;
    logic          pop;
    logic          push;
    logic          push_ext;
    logic          push_rel;
    logic          err_ev;
    logic          is_pfx;

    assign full     = (fifo_count == CW'(DEPTH));
    assign data_req = ~full;
    assign accept   = data_req & data_ack;
    assign ev_valid = (fifo_count != '0);
    assign pop      = ev_rd & ev_valid;
    assign is_pfx   = (data == 8'hE0) || (data == 8'hF0);

    assign {ev_ext, ev_rel, ev_code} = ev_valid ? mem[rd_ptr] : 10'd0;

    always_comb begin
        push     = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        err_ev   = 1'b0;
        nxt      = state;
        if (accept) begin
            // overrun codes and parity errors abort any partial prefix
            if (data_err || data == 8'h00 || data == 8'hFF) begin
                err_ev = 1'b1;
                nxt    = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (data == 8'hE0)      nxt = EXT;
                        else if (data == 8'hF0) nxt = BRK;
                        else                    push = 1'b1;
                    end
                    EXT: begin
                        if (data == 8'hF0) begin
                            nxt = EXT_BRK;
                        end else if (data != 8'hE0) begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            nxt      = IDLE;
                        end
                    end
                    BRK: begin
                        nxt = IDLE;
                        if (is_pfx) begin
                            err_ev = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_rel = 1'b1;
                        end
                    end
                    default: begin
                        nxt = IDLE;
                        if (is_pfx) begin
                            err_ev = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            push_rel = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_ext, push_rel, data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (err_ev && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with an event scoreboard queue.
module tb_ps2_scancode_decoder;

    logic       clk = 0;
    logic       rst = 1;
    logic       data_req;
    logic [7:0] data = 0;
    logic       data_err = 0;
    logic       data_ack = 0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       ev_rd = 0;
    logic [3:0] fifo_count;
    logic [7:0] err_count;
    logic       clr_err = 0;

    int total = 0;
    int bad = 0;
    logic [9:0] q[$];

    ps2_scancode_decoder #(.DEPTH(8), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data(data),
        .data_err(data_err), .data_ack(data_ack), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel),
        .ev_rd(ev_rd), .fifo_count(fifo_count), .err_count(err_count),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        int n = 0;
        data = b;
        data_err = e;
        data_ack = 1;
        while (!data_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        data_ack = 0;
        data_err = 0;
    endtask

    task automatic send_ev(input logic [7:0] b, input logic x, input logic r);
        send(b, 0);
        q.push_back({x, r, b});
    endtask

    task automatic pop_check();
        logic [9:0] exp;
        if (q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            exp = q.pop_front();
            chk("head_valid", ev_valid, 1);
            chk("head_event", {ev_ext, ev_rel, ev_code}, exp);
        end
        ev_rd = 1;
        @(posedge clk); #1;
        ev_rd = 0;
    endtask

    task automatic drain();
        while (q.size() > 0) pop_check();
        chk("drained_empty", ev_valid, 0);
    endtask

    task automatic push_pop(input logic [7:0] b);
        logic [9:0] exp;
        exp = q.pop_front();
        chk("pp_head", {ev_ext, ev_rel, ev_code}, exp);
        data = b;
        data_ack = 1;
        ev_rd = 1;
        @(posedge clk); #1;
        data_ack = 0;
        ev_rd = 0;
        q.push_back({2'b00, b});
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", data_req, 1);
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_code", {ev_ext, ev_rel, ev_code}, 0);
        rst = 0;
        @(posedge clk); #1;

        // make code
        send_ev(8'h1C, 0, 0);
        chk("make_count", fifo_count, 1);
        chk("make_valid", ev_valid, 1);
        drain();

        // prefix decoding
        send(8'hF0, 0); send_ev(8'h1C, 0, 1);
        send(8'hE0, 0); send_ev(8'h75, 1, 0);
        send(8'hE0, 0); send(8'hF0, 0); send_ev(8'h75, 1, 1);
        send(8'hE0, 0); send(8'hE0, 0); send_ev(8'h75, 1, 0);
        chk("pfx_count", fifo_count, 4);
        drain();
        chk("pfx_err", err_count, 0);

        // errors
        send(8'hE0, 0); send(8'h12, 1); send_ev(8'h1C, 0, 0);
        chk("par_err", err_count, 1);
        drain();
        send(8'hF0, 0); send(8'hF0, 0);
        chk("brk_err", err_count, 2);
        chk("brk_noev", fifo_count, 0);
        send(8'h00, 0);
        chk("ovr_err", err_count, 3);
        send(8'hFF, 0);
        chk("ovr_ff_err", err_count, 4);
        chk("ovr_noev", ev_valid, 0);

        // backpressure
        for (int i = 0; i < 8; i++) send_ev(8'h20 + 8'(i), 0, 0);
        chk("full_count", fifo_count, 8);
        chk("full_req", data_req, 0);
        data = 8'h30;
        data_ack = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("held_count", fifo_count, 8);
        q.push_back({2'b00, 8'h30});
        pop_check();
        chk("req_rise", data_req, 1);
        @(posedge clk); #1;
        data_ack = 0;
        chk("refill_count", fifo_count, 8);
        drain();

        // simultaneous push and pop
        for (int i = 0; i < 3; i++) send_ev(8'h40 + 8'(i), 0, 0);
        chk("sp3_pre", fifo_count, 3);
        push_pop(8'h43);
        chk("sp3_count", fifo_count, 3);
        chk("sp3_head", ev_code, 8'h41);
        drain();
        send_ev(8'h50, 0, 0);
        push_pop(8'h51);
        chk("sp1_count", fifo_count, 1);
        chk("sp1_head", ev_code, 8'h51);
        drain();

        // pointer wrap over 20 events
        for (int i = 0; i < 20; i++) begin
            send_ev(8'h60 + 8'(i), 0, 0);
            if (fifo_count >= 5) pop_check();
        end
        drain();

        // saturation then reset mid-prefix
        for (int i = 0; i < 260; i++) send(8'h00, 0);
        chk("sat_err", err_count, 8'hFF);
        send(8'h11, 0);
        send(8'hE0, 0);
        rst = 1;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_err", err_count, 0);
        chk("arst_valid", ev_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        send_ev(8'h75, 0, 0);
        drain();

        // clr_err priority
        send(8'h00, 0);
        chk("pre_clr", err_count, 1);
        data = 8'h00;
        data_ack = 1;
        clr_err = 1;
        @(posedge clk); #1;
        data_ack = 0;
        clr_err = 0;
        chk("clr_prio", err_count, 0);
        chk("clr_noev", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
